// File: rtl/btb_pkg.sv
// Shared BTB types and sizing for the update scheduler and the BTB itself.
package btb_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } btb_upd_t;

endpackage

// File: rtl/btb_update_sched_if.sv
// Execute-lane request handshakes plus the serialised BTB update port and status.
interface btb_update_sched_if
  import btb_pkg::*;
();

  logic                 flush;
  logic                 req0_valid;
  logic                 req0_ready;
  logic [XLEN-1:0]      req0_pc;
  logic [XLEN-1:0]      req0_target;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [XLEN-1:0]      req1_pc;
  logic [XLEN-1:0]      req1_target;
  logic                 btb_hold;
  logic                 btb_is_req_pc;
  logic [XLEN-1:0]      btb_req_pc;
  logic [XLEN-1:0]      btb_predict_target;
  logic [PTR_W:0]       occupancy;
  logic [CNT_W-1:0]     coalesce_cnt;

  modport master (
    output flush, req0_valid, req0_pc, req0_target,
           req1_valid, req1_pc, req1_target, btb_hold,
    input  req0_ready, req1_ready, btb_is_req_pc, btb_req_pc,
           btb_predict_target, occupancy, coalesce_cnt
  );

  modport slave (
    input  flush, req0_valid, req0_pc, req0_target,
           req1_valid, req1_pc, req1_target, btb_hold,
    output req0_ready, req1_ready, btb_is_req_pc, btb_req_pc,
           btb_predict_target, occupancy, coalesce_cnt
  );

endinterface

// File: rtl/btb_update_sched_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips only after a contested grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    rr_d  = rr_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = rr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (update_i && (&req_i)) rr_d = ~rr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/btb_update_sched.sv
// Serialises two lanes of branch-resolution updates onto the single BTB update port,
// buffering in a small FIFO and merging repeat PCs in place.
module btb_update_sched
  import btb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  btb_update_sched_if.slave  bus
);

  btb_upd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, hit_idx;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] coal_cnt_q, coal_cnt_d;

  logic       kill, empty, full, deq, hit, accept, enq, coal;
  logic [1:0] gnt;
  btb_upd_t   win;

  assign kill  = reset | bus.flush;
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign deq   = !empty && !bus.btb_hold && !kill;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({bus.req1_valid, bus.req0_valid}),
    .update_i (accept),
    .gnt_o    (gnt)
  );

  always_comb begin
    win = gnt[1] ? '{pc: bus.req1_pc, target: bus.req1_target}
                 : '{pc: bus.req0_pc, target: bus.req0_target};
  end

  // CAM over live entries oldest to newest, so the newest match wins; the head is
  // excluded while it dequeues so the fresh target still gets its own strobe.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PTR_W+1)'(k) < count_q && !(k == 0 && deq) &&
          mem_q[head_q + PTR_W'(k)].pc == win.pc) begin
        hit     = 1'b1;
        hit_idx = head_q + PTR_W'(k);
      end
    end
  end

  assign accept = (|gnt) && !kill && (hit || !full || deq);
  assign enq    = accept && !hit;
  assign coal   = accept && hit;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    coal_cnt_d = coal_cnt_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = head_q + 1'b1;
      if (enq) tail_d = tail_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
      if (coal && coal_cnt_q != '1) coal_cnt_d = coal_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      coal_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      coal_cnt_q <= coal_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (enq)  mem_q[tail_q]         <= win;
    if (coal) mem_q[hit_idx].target <= win.target;
  end

  assign bus.req0_ready         = gnt[0] && accept;
  assign bus.req1_ready         = gnt[1] && accept;
  assign bus.btb_is_req_pc      = deq;
  assign bus.btb_req_pc         = empty ? '0 : mem_q[head_q].pc;
  assign bus.btb_predict_target = empty ? '0 : mem_q[head_q].target;
  assign bus.occupancy          = count_q;
  assign bus.coalesce_cnt       = coal_cnt_q;

endmodule
